// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract computed DIGIT bits per cycle through a registered carry
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] ad, bd, dsum;
  logic dcarry, last;
  always_comb begin
    ad = a_q[cnt_q*DIGIT +: DIGIT];
    bd = b_q[cnt_q*DIGIT +: DIGIT];
    {dcarry, dsum} = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, carry_q};
    last = cnt_q == CW'(NDIG - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      cnt_d = '0;
      a_d = a;
      b_d = b ^ {WIDTH{sub}};
      carry_d = sub | c_in;
    end else if (state_q == RUN) begin
      sum_d[cnt_q*DIGIT +: DIGIT] = dsum;
      carry_d = dcarry;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        c_out_d = dcarry;
        // carry into the MSB recovered from the MSB's own sum bit
        ovf_d = dcarry ^ ad[DIGIT-1] ^ bd[DIGIT-1] ^ dsum[DIGIT-1];
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign c_out = c_out_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: three configurations (16/4, 4/1, 4/4) checked every cycle against an arithmetic model
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] in_valid = '0, in_ready, c_in = '0, sub = '0, out_valid, out_ready = '0, c_out, ovf;
  logic [15:0] a [3], b [3], sum_o [3];
  int checks = 0, failures = 0, cyc = 0;
  bit pend [3], fresh [3];
  int due [3];
  logic [15:0] es [3];
  logic ec [3], eo [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int W = g == 0 ? 16 : 4;
    localparam int D = g == 1 ? 1 : 4;
    logic [W-1:0] s;
    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a[g][W-1:0]), .b(b[g][W-1:0]), .c_in(c_in[g]), .sub(sub[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .sum(s), .c_out(c_out[g]), .overflow(ovf[g])
    );
    assign sum_o[g] = 16'(s);
  end
  function automatic int wid(input int g);
    return g == 0 ? 16 : 4;
  endfunction
  function automatic int ndig(input int g);
    return g == 2 ? 1 : 4;
  endfunction
  function automatic void model(input int w, input logic [15:0] av, bv, input logic ci, sb,
                                output logic [15:0] s, output logic c, o);
    longint m, ua, ub, sa, sbv, r, sr;
    m = longint'(1) << w;
    ua = longint'(av) & (m - 1);
    ub = longint'(bv) & (m - 1);
    sa = ua >= m / 2 ? ua - m : ua;
    sbv = ub >= m / 2 ? ub - m : ub;
    if (sb) begin
      r = ua - ub;
      c = ua >= ub;
      sr = sa - sbv;
    end else begin
      r = ua + ub + longint'(ci);
      c = r >= m;
      sr = sa + sbv + longint'(ci);
    end
    s = 16'(r & (m - 1));
    o = sr < -(m / 2) || sr >= m / 2;
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        pend[g] = 0;
        fresh[g] = 1;
      end else if (!pend[g] && in_valid[g]) begin
        pend[g] = 1;
        fresh[g] = 0;
        due[g] = cyc + 1 + ndig(g);
        model(wid(g), a[g], b[g], c_in[g], sub[g], es[g], ec[g], eo[g]);
      end else if (pend[g] && cyc >= due[g] && out_ready[g]) begin
        pend[g] = 0;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int g = 0; g < 3; g++) begin
        bit ev;
        ev = pend[g] && cyc >= due[g];
        chk($sformatf("out_valid%0d", g), 16'(out_valid[g]), 16'(ev));
        chk($sformatf("in_ready%0d", g), 16'(in_ready[g]), 16'(!pend[g] && !rst));
        if (ev) begin
          chk($sformatf("sum%0d", g), sum_o[g], es[g]);
          chk($sformatf("c_out%0d", g), 16'(c_out[g]), 16'(ec[g]));
          chk($sformatf("overflow%0d", g), 16'(ovf[g]), 16'(eo[g]));
        end
        if (fresh[g]) begin
          chk($sformatf("reset_sum%0d", g), sum_o[g], 16'h0);
          chk($sformatf("reset_flags%0d", g), {14'b0, c_out[g], ovf[g]}, 16'h0);
        end
      end
    end
  end
  task automatic op(input int g, input logic [15:0] av, bv, input logic ci, sb, input int hold, input bit pre,
                    output logic [15:0] rs, output logic rc, ro, output int lat);
    int n = 0;
    a[g] = av; b[g] = bv; c_in[g] = ci; sub[g] = sb; in_valid[g] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[g] || n == 100) break;
      @(posedge clk); #2;
      n++;
    end
    if (n == 100) chk($sformatf("accept_timeout%0d", g), 16'(n), 16'(0));
    @(posedge clk); #2;
    in_valid[g] = 1'b0;
    a[g] = 16'($urandom); b[g] = 16'($urandom); c_in[g] = 1'($urandom); sub[g] = 1'($urandom);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid[g] || lat == 100) break;
      @(posedge clk); #2;
      lat++;
    end
    rs = sum_o[g]; rc = c_out[g]; ro = ovf[g];
    if (pre) begin
      a[g] = 16'h0003; b[g] = 16'h0004; c_in[g] = 1'b0; sub[g] = 1'b0; in_valid[g] = 1'b1;
    end
    repeat (hold) @(negedge clk);
    out_ready[g] = 1'b1;
    @(posedge clk); #2;
    out_ready[g] = 1'b0;
  endtask
  task automatic dir(input logic [15:0] av, bv, input logic ci, sb, input int hold, input bit pre,
                     input logic [15:0] xs, input logic xc, xo);
    logic [15:0] rs;
    logic rc, ro;
    int lat;
    op(0, av, bv, ci, sb, hold, pre, rs, rc, ro, lat);
    chk($sformatf("lit_sum_%h_%h", av, bv), rs, xs);
    chk($sformatf("lit_c_out_%h_%h", av, bv), 16'(rc), 16'(xc));
    chk($sformatf("lit_ovf_%h_%h", av, bv), 16'(ro), 16'(xo));
    chk($sformatf("lit_latency_%h_%h", av, bv), 16'(lat), 16'd4);
  endtask
  task automatic exh(input int g);
    logic [15:0] rs;
    logic rc, ro;
    int lat;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int m = 0; m < 4; m++) begin
          op(g, 16'(x), 16'(y), m[0], m[1], m & 1, 0, rs, rc, ro, lat);
          chk($sformatf("latency%0d", g), 16'(lat), 16'(ndig(g)));
        end
  endtask
  task automatic rnd(input int cnt);
    logic [15:0] rs;
    logic rc, ro;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), 0, rs, rc, ro, lat);
      chk("latency0", 16'(lat), 16'd4);
    end
  endtask
  initial begin
    for (int g = 0; g < 3; g++) begin
      a[g] = '0;
      b[g] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    dir(16'h1234, 16'h0FCD, 1, 0, 0, 0, 16'h2202, 0, 0);
    dir(16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 0);
    dir(16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0, 1);
    dir(16'h0005, 16'h0007, 1, 1, 0, 0, 16'hFFFE, 0, 0);
    dir(16'h8000, 16'h0001, 0, 1, 5, 1, 16'h7FFF, 1, 1);
    dir(16'h0003, 16'h0004, 0, 0, 0, 0, 16'h0007, 0, 0);
    a[0] = 16'h1111; b[0] = 16'h2222; in_valid[0] = 1'b1;
    @(posedge clk); #2;
    in_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 16'(out_valid[0]), 16'd0);
    chk("midrst_sum", sum_o[0], 16'h0000);
    chk("midrst_in_ready", 16'(in_ready[0]), 16'd1);
    @(posedge clk); #2;
    dir(16'h0001, 16'h0001, 0, 0, 0, 0, 16'h0002, 0, 0);
    fork
      rnd(40);
      exh(1);
      exh(2);
    join
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
